// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-to-serial UART transmitter with start/finish handshake
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] out_data,
  input  logic       out_start,
  output logic       out_finish,
  output logic       tx
);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  state_t      state_q;
  logic [2:0]  bit_q;
  logic [15:0] baud_q;
  logic [7:0]  shift_q;
  logic        par_q, start_q, tx_q, finish_q;
  logic        req, wrap;
  assign req        = out_start & ~start_q;
  assign wrap       = baud_q == LAST;
  assign tx         = tx_q;
  assign out_finish = finish_q;
  // frame sequencer: tx and out_finish change on the edge that enters each bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      baud_q   <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      start_q  <= 1'b0;
      tx_q     <= 1'b1;
      finish_q <= 1'b1;
    end else begin
      start_q <= out_start;
      baud_q  <= (state_q == IDLE || wrap) ? '0 : baud_q + 16'd1;
      case (state_q)
        IDLE: if (req) begin
          shift_q  <= out_data;
          par_q    <= (PARITY == 2) ^ (^out_data);
          state_q  <= START;
          tx_q     <= 1'b0;
          finish_q <= 1'b0;
        end
        START: if (wrap) begin
          state_q <= DATA;
          bit_q   <= '0;
          tx_q    <= shift_q[0];
        end
        DATA: if (wrap) begin
          shift_q <= shift_q >> 1;
          if (bit_q == 3'd7) begin
            bit_q   <= '0;
            state_q <= (PARITY != 0) ? PAR : STOP;
            tx_q    <= (PARITY != 0) ? par_q : 1'b1;
          end else begin
            bit_q <= bit_q + 3'd1;
            tx_q  <= shift_q[1];
          end
        end
        PAR: if (wrap) begin
          state_q <= STOP;
          bit_q   <= '0;
          tx_q    <= 1'b1;
        end
        STOP: if (wrap) begin
          if (bit_q == 3'(STOP_BITS - 1)) begin
            state_q  <= IDLE;
            finish_q <= 1'b1;
          end else begin
            bit_q <= bit_q + 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed checks of five parity/stop variants at 4 clocks per bit
module tb_uart_tx_serializer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       out_start = 1'b0;
  logic [7:0] out_data = 8'h00;
  wire  [4:0] tx_w, fin_w;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 5; g++) begin : g_dut
    uart_tx_serializer #(
      .CLKS_PER_BIT(4),
      .PARITY(g == 0 ? 0 : (g % 2 == 1 ? 1 : 2)),
      .STOP_BITS(g >= 3 ? 2 : 1)
    ) dut (
      .clk(clk), .reset(reset), .out_data(out_data), .out_start(out_start),
      .out_finish(fin_w[g]), .tx(tx_w[g])
    );
  end
  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int par_of(input int k);
    return k == 0 ? 0 : (k % 2 == 1 ? 1 : 2);
  endfunction
  function automatic int frame_len(input int k);
    return 9 + ((par_of(k) != 0) ? 1 : 0) + (k >= 3 ? 2 : 1);
  endfunction
  function automatic logic exp_bit(input int k, input logic [7:0] d, input int n);
    int b = n / 4;
    if (n >= frame_len(k) * 4) return 1'b1;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9 && par_of(k) != 0) return par_of(k) == 1 ? ^d : ~^d;
    return 1'b1;
  endfunction
  // mode 0: 1-cycle pulse, 1: held 100 cycles, 2: extra pulse + data change at cycle 10, 4: drain (instance 0 only)
  task automatic frame(input string tag, input logic [7:0] d, input int mode, input int win);
    int errs[5];
    int low[5];
    for (int k = 0; k < 5; k++) begin errs[k] = 0; low[k] = 0; end
    out_data  = d;
    out_start = 1'b1;
    for (int n = 0; n < win; n++) begin
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        if (tx_w[k] !== exp_bit(k, d, n)) errs[k]++;
        if (fin_w[k] === 1'b0) low[k]++;
      end
      if (mode != 1 && n == 0) out_start = 1'b0;
      if (mode == 1 && n == 99) out_start = 1'b0;
      if (mode == 2 && n == 10) begin out_start = 1'b1; out_data = ~d; end
      if (mode == 2 && n == 11) out_start = 1'b0;
    end
    for (int k = 0; k < 5; k++)
      if (mode != 4 || k == 0) begin
        check($sformatf("%s_tx%0d", tag, k), errs[k], 0);
        check($sformatf("%s_low%0d", tag, k), low[k], frame_len(k) * 4);
      end
  endtask
  initial begin
    int bad = 0;
    int edges = 0;
    logic [4:0] prev;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    prev = tx_w;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (tx_w !== 5'h1f || fin_w !== 5'h1f) bad++;
      if (tx_w !== prev) edges++;
      prev = tx_w;
    end
    check("idle_level", bad, 0);
    check("idle_edges", edges, 0);
    frame("a5", 8'hA5, 0, 60);
    frame("03", 8'h03, 0, 60);
    frame("hold", 8'hC3, 1, 110);
    frame("repulse", 8'h3C, 2, 60);
    out_data  = 8'h96;
    out_start = 1'b1;
    for (int n = 0; n < 18; n++) begin
      @(negedge clk);
      if (n == 0) out_start = 1'b0;
      if (n == 17) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    check("rst_tx", int'(tx_w), 31);
    check("rst_fin", int'(fin_w), 31);
    frame("5a", 8'h5A, 0, 60);
    frame("drain00", 8'h00, 4, 41);
    frame("drainff", 8'hFF, 4, 41);
    frame("drain41", 8'h41, 4, 41);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
